// File: rtl/cpu_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU and branch-condition
// codes, and the ctrl_t control bundle carried in the ID/EX register.
package cpu_pkg;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MULD = 7'b0000001;

    localparam logic [3:0] ALU_OP_NONE = 4'b0000;
    localparam logic [3:0] ALU_OP_ADD  = 4'b0001;
    localparam logic [3:0] ALU_OP_MUL  = 4'b0010;
    localparam logic [3:0] ALU_OP_SLT  = 4'b0011;
    localparam logic [3:0] ALU_OP_XOR  = 4'b0100;
    localparam logic [3:0] ALU_OP_SLTU = 4'b0101;
    localparam logic [3:0] ALU_OP_OR   = 4'b0110;
    localparam logic [3:0] ALU_OP_AND  = 4'b0111;
    localparam logic [3:0] ALU_OP_SLL  = 4'b1000;
    localparam logic [3:0] ALU_OP_SUB  = 4'b1001;
    localparam logic [3:0] ALU_OP_SRL  = 4'b1010;
    localparam logic [3:0] ALU_OP_SRA  = 4'b1011;

    localparam logic [2:0] BR_NONE   = 3'd0;
    localparam logic [2:0] BR_EQ     = 3'd1;
    localparam logic [2:0] BR_NE     = 3'd2;
    localparam logic [2:0] BR_LT     = 3'd3;
    localparam logic [2:0] BR_GE     = 3'd4;
    localparam logic [2:0] BR_LTU    = 3'd5;
    localparam logic [2:0] BR_GEU    = 3'd6;
    localparam logic [2:0] BR_ALWAYS = 3'd7;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic [3:0] alu_op;
        logic       has_imm;
        logic       a_pc;
        logic       rf_we;
        logic       mem_re;
        logic       mem_we;
        logic [2:0] br_cond;
        logic       link;
        logic       indirect;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/instr_decoder.sv
// Combinational RV32I instruction decoder: instr -> ctrl_t, 32-bit
// immediate, source-register usage flags and illegal flag.
// Ports: instr in; ctrl, imm, uses_rs1, uses_rs2, illegal out.
// Optional: `define RV_M_EN decodes MUL (other M ops stay illegal).
import cpu_pkg::*;

module instr_decoder (
    input  logic [31:0] instr,
    output ctrl_t       ctrl,
    output logic [31:0] imm,
    output logic        uses_rs1,
    output logic        uses_rs2,
    output logic        illegal
);

    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;
    logic        bad;

    assign opc = instr[6:0];
    assign f3  = instr[14:12];
    assign f7  = instr[31:25];
    assign rs1 = instr[19:15];
    assign rs2 = instr[24:20];
    assign rd  = instr[11:7];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7],
                    instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12],
                    instr[20], instr[30:21], 1'b0};

    always_comb begin
        ctrl     = '0;
        imm      = 32'b0;
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        bad      = 1'b0;
        case (opc)
            OPC_OP_IMM: begin
                ctrl.rd      = rd;
                ctrl.rs1     = rs1;
                ctrl.has_imm = 1'b1;
                ctrl.rf_we   = 1'b1;
                ctrl.alu_op  = ALU_OP_ADD;
                uses_rs1     = 1'b1;
                imm          = imm_i;
                case (f3)
                    3'b000: ctrl.alu_op = ALU_OP_ADD;
                    3'b010: ctrl.alu_op = ALU_OP_SLT;
                    3'b011: ctrl.alu_op = ALU_OP_SLTU;
                    3'b100: ctrl.alu_op = ALU_OP_XOR;
                    3'b110: ctrl.alu_op = ALU_OP_OR;
                    3'b111: ctrl.alu_op = ALU_OP_AND;
                    3'b001: begin
                        if (f7 == F7_BASE) ctrl.alu_op = ALU_OP_SLL;
                        else               bad = 1'b1;
                    end
                    3'b101: begin
                        if (f7 == F7_BASE)     ctrl.alu_op = ALU_OP_SRL;
                        else if (f7 == F7_ALT) ctrl.alu_op = ALU_OP_SRA;
                        else                   bad = 1'b1;
                    end
                endcase
            end
            OPC_OP: begin
                ctrl.rd     = rd;
                ctrl.rs1    = rs1;
                ctrl.rs2    = rs2;
                ctrl.rf_we  = 1'b1;
                ctrl.alu_op = ALU_OP_ADD;
                uses_rs1    = 1'b1;
                uses_rs2    = 1'b1;
                case (f7)
                    F7_BASE: begin
                        case (f3)
                            3'b000: ctrl.alu_op = ALU_OP_ADD;
                            3'b001: ctrl.alu_op = ALU_OP_SLL;
                            3'b010: ctrl.alu_op = ALU_OP_SLT;
                            3'b011: ctrl.alu_op = ALU_OP_SLTU;
                            3'b100: ctrl.alu_op = ALU_OP_XOR;
                            3'b101: ctrl.alu_op = ALU_OP_SRL;
                            3'b110: ctrl.alu_op = ALU_OP_OR;
                            3'b111: ctrl.alu_op = ALU_OP_AND;
                        endcase
                    end
                    F7_ALT: begin
                        if (f3 == 3'b000)      ctrl.alu_op = ALU_OP_SUB;
                        else if (f3 == 3'b101) ctrl.alu_op = ALU_OP_SRA;
                        else                   bad = 1'b1;
                    end
                    F7_MULD: begin
`ifdef RV_M_EN
                        if (f3 == 3'b000) ctrl.alu_op = ALU_OP_MUL;
                        else              bad = 1'b1;
`else
                        bad = 1'b1;
`endif
                    end
                    default: bad = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                ctrl.rd      = rd;
                ctrl.rs1     = rs1;
                ctrl.alu_op  = ALU_OP_ADD;
                ctrl.has_imm = 1'b1;
                ctrl.rf_we   = 1'b1;
                ctrl.mem_re  = 1'b1;
                uses_rs1     = 1'b1;
                imm          = imm_i;
                if (f3 != 3'b010) bad = 1'b1;
            end
            OPC_STORE: begin
                ctrl.rs1     = rs1;
                ctrl.rs2     = rs2;
                ctrl.alu_op  = ALU_OP_ADD;
                ctrl.has_imm = 1'b1;
                ctrl.mem_we  = 1'b1;
                uses_rs1     = 1'b1;
                uses_rs2     = 1'b1;
                imm          = imm_s;
                if (f3 != 3'b010) bad = 1'b1;
            end
            OPC_BRANCH: begin
                ctrl.rs1    = rs1;
                ctrl.rs2    = rs2;
                ctrl.alu_op = ALU_OP_SUB;
                uses_rs1    = 1'b1;
                uses_rs2    = 1'b1;
                imm         = imm_b;
                case (f3)
                    3'b000:  ctrl.br_cond = BR_EQ;
                    3'b001:  ctrl.br_cond = BR_NE;
                    3'b100:  ctrl.br_cond = BR_LT;
                    3'b101:  ctrl.br_cond = BR_GE;
                    3'b110:  ctrl.br_cond = BR_LTU;
                    3'b111:  ctrl.br_cond = BR_GEU;
                    default: bad = 1'b1;
                endcase
            end
            OPC_JAL: begin
                ctrl.rd      = rd;
                ctrl.alu_op  = ALU_OP_ADD;
                ctrl.rf_we   = 1'b1;
                ctrl.br_cond = BR_ALWAYS;
                ctrl.link    = 1'b1;
                imm          = imm_j;
            end
            OPC_JALR: begin
                ctrl.rd       = rd;
                ctrl.rs1      = rs1;
                ctrl.alu_op   = ALU_OP_ADD;
                ctrl.has_imm  = 1'b1;
                ctrl.rf_we    = 1'b1;
                ctrl.br_cond  = BR_ALWAYS;
                ctrl.link     = 1'b1;
                ctrl.indirect = 1'b1;
                uses_rs1      = 1'b1;
                imm           = imm_i;
                if (f3 != 3'b000) bad = 1'b1;
            end
            OPC_LUI: begin
                ctrl.rd      = rd;
                ctrl.alu_op  = ALU_OP_ADD;
                ctrl.has_imm = 1'b1;
                ctrl.rf_we   = 1'b1;
                imm          = imm_u;
            end
            OPC_AUIPC: begin
                ctrl.rd      = rd;
                ctrl.alu_op  = ALU_OP_ADD;
                ctrl.has_imm = 1'b1;
                ctrl.a_pc    = 1'b1;
                ctrl.rf_we   = 1'b1;
                imm          = imm_u;
            end
            default: bad = 1'b1;
        endcase
        // Illegal ops still travel to EX but must have no side effects
        // and must never cause a load-use stall.
        if (bad) begin
            ctrl         = '0;
            ctrl.illegal = 1'b1;
            imm          = 32'b0;
            uses_rs1     = 1'b0;
            uses_rs2     = 1'b0;
        end
    end

    assign illegal = ctrl.illegal;

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage holding the ID/EX register, with valid/ready on
// both sides, load-use bubble insertion, flush and an illegal counter.
// Ports: clk, rst (sync, active-high); fetch side in_valid/in_ready/
// in_instr/in_pc; flush; EX side out_valid/out_ready and out_* fields;
// illegal_cnt. Optional: `define RV_M_EN enables MUL decode.
import cpu_pkg::*;

module decode_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [XLEN-1:0]  out_imm,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [4:0]       out_rd,
    output logic [3:0]       out_alu_op,
    output logic             out_has_imm,
    output logic             out_a_pc,
    output logic             out_rf_we,
    output logic             out_mem_re,
    output logic             out_mem_we,
    output logic [2:0]       out_br_cond,
    output logic             out_link,
    output logic             out_indirect,
    output logic             out_illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    ctrl_t             dec_ctrl;
    logic [31:0]       dec_imm;
    logic              dec_uses_rs1;
    logic              dec_uses_rs2;
    logic              dec_illegal;
    logic [XLEN-1:0]   imm_ext;

    logic              valid_q, valid_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   imm_q, imm_d;
    ctrl_t             ctrl_q, ctrl_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              hazard;
    logic              accept;
    logic              drain;

    instr_decoder u_dec (
        .instr    (in_instr),
        .ctrl     (dec_ctrl),
        .imm      (dec_imm),
        .uses_rs1 (dec_uses_rs1),
        .uses_rs2 (dec_uses_rs2),
        .illegal  (dec_illegal)
    );

    assign imm_ext = XLEN'($signed(dec_imm));

    // Load in ID/EX whose result the incoming op needs: hold it back
    // one cycle so EX can forward from the memory stage.
    assign hazard = valid_q && ctrl_q.mem_re && (ctrl_q.rd != 5'd0) &&
                    ((dec_uses_rs1 && dec_ctrl.rs1 == ctrl_q.rd) ||
                     (dec_uses_rs2 && dec_ctrl.rs2 == ctrl_q.rd));

    assign drain    = !valid_q || out_ready;
    assign in_ready = !rst && drain && !hazard && !flush;
    assign accept   = in_valid && in_ready;

    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        imm_d   = imm_q;
        ctrl_d  = ctrl_q;
        cnt_d   = cnt_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d = 1'b1;
            pc_d    = in_pc;
            imm_d   = imm_ext;
            ctrl_d  = dec_ctrl;
            if (dec_illegal && !(&cnt_q)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (drain) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            imm_q   <= '0;
            ctrl_q  <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            imm_q   <= imm_d;
            ctrl_q  <= ctrl_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid    = valid_q;
    assign out_pc       = pc_q;
    assign out_imm      = imm_q;
    assign out_rs1      = ctrl_q.rs1;
    assign out_rs2      = ctrl_q.rs2;
    assign out_rd       = ctrl_q.rd;
    assign out_alu_op   = ctrl_q.alu_op;
    assign out_has_imm  = ctrl_q.has_imm;
    assign out_a_pc     = ctrl_q.a_pc;
    assign out_rf_we    = ctrl_q.rf_we;
    assign out_mem_re   = ctrl_q.mem_re;
    assign out_mem_we   = ctrl_q.mem_we;
    assign out_br_cond  = ctrl_q.br_cond;
    assign out_link     = ctrl_q.link;
    assign out_indirect = ctrl_q.indirect;
    assign out_illegal  = ctrl_q.illegal;
    assign illegal_cnt  = cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: decode vector table plus
// load-use, hold, flush and counter-saturation sequences.
module tb_decode_stage;

    localparam int XLEN  = 32;
    localparam int CNT_W = 4;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [XLEN-1:0]  in_pc;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_pc;
    logic [XLEN-1:0]  out_imm;
    logic [4:0]       out_rs1;
    logic [4:0]       out_rs2;
    logic [4:0]       out_rd;
    logic [3:0]       out_alu_op;
    logic             out_has_imm;
    logic             out_a_pc;
    logic             out_rf_we;
    logic             out_mem_re;
    logic             out_mem_we;
    logic [2:0]       out_br_cond;
    logic             out_link;
    logic             out_indirect;
    logic             out_illegal;
    logic [CNT_W-1:0] illegal_cnt;

    int errors = 0;
    int checks = 0;
    int cnt_exp = 0;

    decode_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_instr     (in_instr),
        .in_pc        (in_pc),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pc       (out_pc),
        .out_imm      (out_imm),
        .out_rs1      (out_rs1),
        .out_rs2      (out_rs2),
        .out_rd       (out_rd),
        .out_alu_op   (out_alu_op),
        .out_has_imm  (out_has_imm),
        .out_a_pc     (out_a_pc),
        .out_rf_we    (out_rf_we),
        .out_mem_re   (out_mem_re),
        .out_mem_we   (out_mem_we),
        .out_br_cond  (out_br_cond),
        .out_link     (out_link),
        .out_indirect (out_indirect),
        .out_illegal  (out_illegal),
        .illegal_cnt  (illegal_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic        full;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [3:0]  alu;
        logic        has_imm;
        logic        a_pc;
        logic        rf_we;
        logic        mem_re;
        logic        mem_we;
        logic [2:0]  br;
        logic        link;
        logic        ind;
        logic        ill;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        logic [31:0] instr, logic [4:0] rs1, logic [4:0] rs2,
        logic [4:0] rd, logic [31:0] imm, logic [3:0] alu,
        logic has_imm, logic a_pc, logic rf_we, logic mem_re,
        logic mem_we, logic [2:0] br, logic link, logic ind);
        vec_t v;
        v.instr = instr; v.full = 1'b1;
        v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.imm = imm; v.alu = alu;
        v.has_imm = has_imm; v.a_pc = a_pc; v.rf_we = rf_we;
        v.mem_re = mem_re; v.mem_we = mem_we; v.br = br;
        v.link = link; v.ind = ind; v.ill = 1'b0;
        return v;
    endfunction

    function automatic vec_t mk_ill(logic [31:0] instr);
        vec_t v;
        v = mk(instr, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        v.full = 1'b0;
        v.ill  = 1'b1;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_vec(vec_t v, logic [31:0] pc);
        chk("valid", 32'(out_valid), 1);
        chk("illegal", 32'(out_illegal), 32'(v.ill));
        chk("rf_we", 32'(out_rf_we), 32'(v.rf_we));
        chk("mem_re", 32'(out_mem_re), 32'(v.mem_re));
        chk("mem_we", 32'(out_mem_we), 32'(v.mem_we));
        chk("br_cond", 32'(out_br_cond), 32'(v.br));
        chk("pc", out_pc, pc);
        if (v.full) begin
            chk("rs1", 32'(out_rs1), 32'(v.rs1));
            chk("rs2", 32'(out_rs2), 32'(v.rs2));
            chk("rd", 32'(out_rd), 32'(v.rd));
            chk("imm", out_imm, v.imm);
            chk("alu_op", 32'(out_alu_op), 32'(v.alu));
            chk("has_imm", 32'(out_has_imm), 32'(v.has_imm));
            chk("a_pc", 32'(out_a_pc), 32'(v.a_pc));
            chk("link", 32'(out_link), 32'(v.link));
            chk("indirect", 32'(out_indirect), 32'(v.ind));
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_instr = 32'h0;
        in_pc = 32'h0;
        flush = 1'b0;
        out_ready = 1'b1;

        // rs1 rs2 rd imm alu hi apc we re wr br lk ind
        vecs.push_back(mk(32'h00500093, 0, 0, 1, 32'd5, 4'b0001,
                          1, 0, 1, 0, 0, 3'd0, 0, 0));
        vecs.push_back(mk(32'hFE000EE3, 0, 0, 0, 32'hFFFFFFFC, 4'b1001,
                          0, 0, 0, 0, 0, 3'd1, 0, 0));
        vecs.push_back(mk(32'h002101B3, 2, 2, 3, 32'd0, 4'b0001,
                          0, 0, 1, 0, 0, 3'd0, 0, 0));
        vecs.push_back(mk(32'h407302B3, 6, 7, 5, 32'd0, 4'b1001,
                          0, 0, 1, 0, 0, 3'd0, 0, 0));
        vecs.push_back(mk(32'h40325213, 4, 0, 4, 32'h403, 4'b1011,
                          1, 0, 1, 0, 0, 3'd0, 0, 0));
        vecs.push_back(mk(32'h0020A423, 1, 2, 0, 32'd8, 4'b0001,
                          1, 0, 0, 0, 1, 3'd0, 0, 0));
        vecs.push_back(mk(32'h123453B7, 0, 0, 7, 32'h12345000, 4'b0001,
                          1, 0, 1, 0, 0, 3'd0, 0, 0));
        vecs.push_back(mk(32'hFFFFF417, 0, 0, 8, 32'hFFFFF000, 4'b0001,
                          1, 1, 1, 0, 0, 3'd0, 0, 0));
        vecs.push_back(mk(32'h008000EF, 0, 0, 1, 32'd8, 4'b0001,
                          0, 0, 1, 0, 0, 3'd7, 1, 0));
        vecs.push_back(mk(32'h00008067, 1, 0, 0, 32'd0, 4'b0001,
                          1, 0, 1, 0, 0, 3'd7, 1, 1));
        vecs.push_back(mk(32'h0020E863, 1, 2, 0, 32'd16, 4'b1001,
                          0, 0, 0, 0, 0, 3'd5, 0, 0));
        vecs.push_back(mk(32'hFFF53493, 10, 0, 9, 32'hFFFFFFFF, 4'b0101,
                          1, 0, 1, 0, 0, 3'd0, 0, 0));
        vecs.push_back(mk_ill(32'h04D665B3));
        vecs.push_back(mk_ill(32'h40101093));
        vecs.push_back(mk_ill(32'hFFFFFFFF));
`ifdef RV_M_EN
        vecs.push_back(mk(32'h022081B3, 1, 2, 3, 32'd0, 4'b0010,
                          0, 0, 1, 0, 0, 3'd0, 0, 0));
`else
        vecs.push_back(mk_ill(32'h022081B3));
`endif
        vecs.push_back(mk(32'h0000A103, 1, 0, 2, 32'd0, 4'b0001,
                          1, 0, 1, 1, 0, 3'd0, 0, 0));

        // Reset state
        tick();
        tick();
        chk("rst in_ready", 32'(in_ready), 0);
        chk("rst out_valid", 32'(out_valid), 0);
        chk("rst rd", 32'(out_rd), 0);
        chk("rst imm", out_imm, 0);
        chk("rst cnt", 32'(illegal_cnt), 0);
        rst = 1'b0;
        tick();

        // Decode table, one op per cycle
        foreach (vecs[i]) begin
            in_valid = 1'b1;
            in_instr = vecs[i].instr;
            in_pc = 32'h100 + 32'(i) * 4;
            #1;
            chk("tbl in_ready", 32'(in_ready), 1);
            tick();
            if (vecs[i].ill && cnt_exp < 15) cnt_exp++;
            chk_vec(vecs[i], 32'h100 + 32'(i) * 4);
            chk("tbl cnt", 32'(illegal_cnt), 32'(cnt_exp));
        end
        in_valid = 1'b0;
        tick();
        chk("drain valid", 32'(out_valid), 0);

        // Load-use: LW x2 then ADD x3,x2,x2
        in_valid = 1'b1;
        in_instr = 32'h0000A103;
        in_pc = 32'h200;
        tick();
        chk("lw valid", 32'(out_valid), 1);
        chk("lw mem_re", 32'(out_mem_re), 1);
        in_instr = 32'h002101B3;
        in_pc = 32'h204;
        #1;
        chk("hz in_ready", 32'(in_ready), 0);
        tick();
        chk("bubble valid", 32'(out_valid), 0);
        chk("after bubble in_ready", 32'(in_ready), 1);
        tick();
        chk("dep valid", 32'(out_valid), 1);
        chk("dep rd", 32'(out_rd), 3);
        chk("dep pc", out_pc, 32'h204);

        // Hold: ADDI stalled by out_ready=0 for 3 cycles
        in_instr = 32'h00500093;
        in_pc = 32'h300;
        tick();
        chk("hold first rd", 32'(out_rd), 1);
        out_ready = 1'b0;
        in_instr = 32'h002101B3;
        in_pc = 32'h304;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("hold in_ready", 32'(in_ready), 0);
            tick();
            chk("hold valid", 32'(out_valid), 1);
            chk("hold rd", 32'(out_rd), 1);
            chk("hold imm", out_imm, 5);
            chk("hold pc", out_pc, 32'h300);
        end
        out_ready = 1'b1;
        #1;
        chk("release in_ready", 32'(in_ready), 1);
        tick();
        chk("release rd", 32'(out_rd), 3);
        chk("release pc", out_pc, 32'h304);

        // Flush while a valid op is held and an illegal op is offered
        out_ready = 1'b0;
        in_instr = 32'hFFFFFFFF;
        flush = 1'b1;
        #1;
        chk("flush in_ready", 32'(in_ready), 0);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush valid", 32'(out_valid), 0);
        chk("flush cnt", 32'(illegal_cnt), 32'(cnt_exp));
        out_ready = 1'b1;
        tick();

        // Counter saturates at all-ones
        in_valid = 1'b1;
        in_instr = 32'hFFFFFFFF;
        for (int k = 0; k < 16; k++) begin
            tick();
            if (cnt_exp < 15) cnt_exp++;
            chk("sat cnt", 32'(illegal_cnt), 32'(cnt_exp));
        end
        in_valid = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
